onchip_ram_dp: RTL and testbench
================================

Name: onchip_ram_dp

Overview:
- Parametrised true dual-port on-chip RAM with two Avalon-MM slave ports, s1 and s2, for Qsys subsystems.
- Generalises the single-port 32-bit/8192-word memory:
  - configurable width and depth;
  - selectable 1- or 2-cycle read latency with readdatavalid;
  - per-port waitrequest;
  - hardware clear-after-reset engine.
- Sits between the Avalon interconnect and the processor/DMA masters as shared scratch memory.

Parameters:
- DATA_WIDTH, 32: word width in bits; multiple of 8, range 8..128.
- ADDR_WIDTH, 13: word-address width; DEPTH = 2**ADDR_WIDTH.
- READ_LATENCY, 1: cycles from accepted read to readdatavalid; legal values 1 or 2.
- CLEAR_ON_RESET, 1: 1 = zero the whole array after reset; 0 = skip the clear and retain contents.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- reset_req  in  1  high stalls both ports (treated like clken=0).
- clken  in  1  global clock enable; low freezes all state.
- s1_address  in  ADDR_WIDTH  port-1 word address.
- s1_byteenable  in  DATA_WIDTH/8  port-1 byte lanes.
- s1_chipselect  in  1  port-1 select.
- s1_read  in  1  port-1 read request.
- s1_write  in  1  port-1 write request.
- s1_writedata  in  DATA_WIDTH  port-1 write data.
- s1_readdata  out  DATA_WIDTH  port-1 read data.
- s1_readdatavalid  out  1  port-1 read data valid.
- s1_waitrequest  out  1  port-1 backpressure.
- s2_*: same set as s1_*, for port 2.
- init_done  out  1  high once the clear has finished (or immediately when CLEAR_ON_RESET=0).

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All state is updated on the rising edge of clk.
- Values during/after reset:
  - readdata = 0, readdatavalid = 0, init_done = 0;
  - waitrequest = 1 on both ports while reset is high;
  - the read pipeline is flushed.
- FSM states: CLEAR, READY.
  - reset enters CLEAR with clr_addr = 0.
  - CLEAR: writes 0 to word clr_addr each enabled cycle and increments it. After DEPTH-1 it moves to READY and sets init_done = 1. Clear takes DEPTH enabled cycles.
  - CLEAR_ON_RESET=0: reset moves the FSM straight to READY. init_done = 1 the first cycle after reset deasserts.
  - reset asserted mid-CLEAR restarts the clear at address 0.
- waitrequest = (state==CLEAR) | ~clken | reset_req | reset, for both ports.
  - A request is accepted when chipselect & (read|write) & ~waitrequest.
  - read and write asserted together: write takes priority; no read data is returned.
- Write: an accepted write updates only the bytes whose byteenable bit is set. Takes effect at the accepting edge.
- Read:
  - READ_LATENCY=1: readdata is registered and readdatavalid pulses 1 cycle after acceptance.
  - READ_LATENCY=2: adds an output register stage; readdatavalid pulses 2 cycles after acceptance.
  - Full throughput on each port: one read per cycle. readdata holds its last value when readdatavalid=0.
- Read-during-write returns OLD data, on the same port and across ports.
- Same-address write on both ports in the same cycle: per byte lane, s1 wins where both byteenables are set; lanes enabled on only one port take that port's data.
- clken=0 or reset_req=1:
  - the pipeline, FSM and clr_addr hold;
  - readdatavalid is forced to 0 while stalled;
  - in-flight valids resume when clken returns.
- Address wrap: the address is used modulo DEPTH; there is no out-of-range error.

Optional Feature:
- Macro: ONCHIP_RAM_DP_PARITY_EN.
- Defined:
  - each byte is stored with an even-parity bit, computed on write; the clear engine writes correct parity;
  - on read, parity is checked and an extra output sN_parity_err (1 bit per port) is asserted aligned with sN_readdatavalid when any lane mismatches;
  - sN_parity_err resets to 0.
- Undefined: no parity storage and no parity_err ports; the array is DATA_WIDTH bits wide.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> waitrequest=1 for exactly 16 cycles after reset falls; init_done rises on cycle 16; reading every address returns 0.
- s1 writes 0xDEADBEEF to addr 5 with byteenable=0xF, then byteenable=0x2 write of 0x0000AA00 -> s2 read of addr 5 returns 0xDEADAAEF; readdatavalid comes 1 cycle (LATENCY=1) or 2 cycles (LATENCY=2) after acceptance.
- Same cycle: s1 writes 0x11111111 and s2 writes 0x22222222 to addr 3, all lanes enabled -> a later read returns 0x11111111. s2 reading addr 3 in that same cycle returns the prior contents.
- Back-to-back s1 reads of addrs 0..7 with clken dropped for 3 cycles mid-burst -> 8 readdatavalid pulses, in order, with none during the stall; correct data.
- reset pulsed when clr_addr=7 -> clear restarts at 0; init_done stays 0 until a full DEPTH-cycle clear completes.
- With PARITY_EN: force-flip one stored bit of addr 2 via a hierarchical deposit -> read of addr 2 asserts parity_err=1 coincident with readdatavalid; a read of addr 1 gives parity_err=0.

Source files
------------

// File: rtl/onchip_ram_dp.sv
// True dual-port Avalon-MM RAM with clear-after-reset engine and 1/2-cycle read latency.
// Define ONCHIP_RAM_DP_PARITY_EN to store an even-parity bit per byte and add sN_parity_err outputs.
module onchip_ram_dp #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 13,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,
`ifdef ONCHIP_RAM_DP_PARITY_EN
  output logic                    s1_parity_err,
  output logic                    s2_parity_err,
`endif
  output logic                    init_done
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef ONCHIP_RAM_DP_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam int MEM_W = NB * LANE_W;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_addr, w_clr_addr_nxt;
  logic                  r_init_done;
  logic [MEM_W-1:0]      r_mem [DEPTH];

  logic                  w_en, w_wait;
  logic [ADDR_WIDTH-1:0] w_addr [2];
  logic [NB-1:0]         w_be   [2];
  logic [DATA_WIDTH-1:0] w_wdat [2];
  logic                  w_wr   [2];
  logic                  w_rd   [2];

  function automatic logic [LANE_W-1:0] enc_lane(input logic [7:0] b);
`ifdef ONCHIP_RAM_DP_PARITY_EN
    return {^b, b};
`else
    return b;
`endif
  endfunction

  function automatic logic [DATA_WIDTH-1:0] dec_word(input logic [MEM_W-1:0] w);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < NB; i++) d[i*8 +: 8] = w[i*LANE_W +: 8];
    return d;
  endfunction

`ifdef ONCHIP_RAM_DP_PARITY_EN
  function automatic logic perr_word(input logic [MEM_W-1:0] w);
    logic e;
    e = 1'b0;
    for (int i = 0; i < NB; i++) e = e | (^w[i*LANE_W +: LANE_W]);
    return e;
  endfunction
`endif

  assign w_en   = clken & ~reset_req;
  assign w_wait = (r_state == ST_CLEAR) | ~w_en | reset;

  assign w_addr[0] = s1_address;
  assign w_addr[1] = s2_address;
  assign w_be[0]   = s1_byteenable;
  assign w_be[1]   = s2_byteenable;
  assign w_wdat[0] = s1_writedata;
  assign w_wdat[1] = s2_writedata;
  // Write wins over a simultaneous read on the same port.
  assign w_wr[0]   = s1_chipselect & s1_write & ~w_wait;
  assign w_wr[1]   = s2_chipselect & s2_write & ~w_wait;
  assign w_rd[0]   = s1_chipselect & s1_read & ~s1_write & ~w_wait;
  assign w_rd[1]   = s2_chipselect & s2_read & ~s2_write & ~w_wait;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_clr_addr  <= '0;
      r_init_done <= 1'b0;
    end else if (w_en) begin
      r_state     <= w_state_nxt;
      r_clr_addr  <= w_clr_addr_nxt;
      r_init_done <= (w_state_nxt == ST_READY);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    if (r_state == ST_CLEAR) begin
      w_clr_addr_nxt = r_clr_addr + 1'b1;
      if (&r_clr_addr) w_state_nxt = ST_READY;
    end
  end

  // s2 lanes are written first so s1 overrides them on a same-address collision.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR && w_en && !reset) r_mem[r_clr_addr] <= '0;
    for (int p = 1; p >= 0; p--) begin
      if (w_wr[p]) begin
        for (int b = 0; b < NB; b++) begin
          if (w_be[p][b]) r_mem[w_addr[p]][b*LANE_W +: LANE_W] <= enc_lane(w_wdat[p][b*8 +: 8]);
        end
      end
    end
  end

  logic                  r_v1    [2];
  logic [DATA_WIDTH-1:0] r_d1    [2];
  logic                  w_vld_q [2];
  logic [DATA_WIDTH-1:0] w_dat_q [2];
`ifdef ONCHIP_RAM_DP_PARITY_EN
  logic                  r_e1    [2];
  logic                  w_err_q [2];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        r_v1[p] <= 1'b0;
        r_d1[p] <= '0;
`ifdef ONCHIP_RAM_DP_PARITY_EN
        r_e1[p] <= 1'b0;
`endif
      end
    end else if (w_en) begin
      for (int p = 0; p < 2; p++) begin
        r_v1[p] <= w_rd[p];
        if (w_rd[p]) begin
          r_d1[p] <= dec_word(r_mem[w_addr[p]]);
`ifdef ONCHIP_RAM_DP_PARITY_EN
          r_e1[p] <= perr_word(r_mem[w_addr[p]]);
`endif
        end
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  r_v2 [2];
    logic [DATA_WIDTH-1:0] r_d2 [2];
`ifdef ONCHIP_RAM_DP_PARITY_EN
    logic                  r_e2 [2];
`endif
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int p = 0; p < 2; p++) begin
          r_v2[p] <= 1'b0;
          r_d2[p] <= '0;
`ifdef ONCHIP_RAM_DP_PARITY_EN
          r_e2[p] <= 1'b0;
`endif
        end
      end else if (w_en) begin
        for (int p = 0; p < 2; p++) begin
          r_v2[p] <= r_v1[p];
          if (r_v1[p]) begin
            r_d2[p] <= r_d1[p];
`ifdef ONCHIP_RAM_DP_PARITY_EN
            r_e2[p] <= r_e1[p];
`endif
          end
        end
      end
    end
    always_comb begin
      for (int p = 0; p < 2; p++) begin
        w_vld_q[p] = r_v2[p];
        w_dat_q[p] = r_d2[p];
`ifdef ONCHIP_RAM_DP_PARITY_EN
        w_err_q[p] = r_e2[p];
`endif
      end
    end
  end else begin : g_lat1
    always_comb begin
      for (int p = 0; p < 2; p++) begin
        w_vld_q[p] = r_v1[p];
        w_dat_q[p] = r_d1[p];
`ifdef ONCHIP_RAM_DP_PARITY_EN
        w_err_q[p] = r_e1[p];
`endif
      end
    end
  end

  // Valids are masked while stalled; the pipeline keeps them for release.
  assign s1_readdatavalid = w_vld_q[0] & w_en & ~reset;
  assign s2_readdatavalid = w_vld_q[1] & w_en & ~reset;
  assign s1_readdata      = w_dat_q[0];
  assign s2_readdata      = w_dat_q[1];
  assign s1_waitrequest   = w_wait;
  assign s2_waitrequest   = w_wait;
  assign init_done        = r_init_done;
`ifdef ONCHIP_RAM_DP_PARITY_EN
  assign s1_parity_err    = w_err_q[0] & s1_readdatavalid;
  assign s2_parity_err    = w_err_q[1] & s2_readdatavalid;
`endif
endmodule

// File: tb/tb_onchip_ram_dp.sv
// Directed bench for onchip_ram_dp: a latency-1 and a latency-2 instance share all inputs.
module tb_onchip_ram_dp;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, reset_req, clken;
  logic [AW-1:0] s1_address, s2_address;
  logic [3:0]    s1_byteenable, s2_byteenable;
  logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [DW-1:0] s1_writedata, s2_writedata;
  logic [DW-1:0] s1_readdata, s2_readdata, l2_s1_readdata, l2_s2_readdata;
  logic          s1_readdatavalid, s2_readdatavalid, l2_s1_readdatavalid, l2_s2_readdatavalid;
  logic          s1_waitrequest, s2_waitrequest, l2_s1_waitrequest, l2_s2_waitrequest;
  logic          init_done, l2_init_done;
`ifdef ONCHIP_RAM_DP_PARITY_EN
  logic          s1_parity_err, s2_parity_err, l2_s1_parity_err, l2_s2_parity_err;
`endif

  onchip_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest),
`ifdef ONCHIP_RAM_DP_PARITY_EN
    .s1_parity_err(s1_parity_err), .s2_parity_err(s2_parity_err),
`endif
    .init_done(init_done)
  );

  onchip_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_dut2 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(l2_s1_readdata), .s1_readdatavalid(l2_s1_readdatavalid), .s1_waitrequest(l2_s1_waitrequest),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(l2_s2_readdata), .s2_readdatavalid(l2_s2_readdatavalid), .s2_waitrequest(l2_s2_waitrequest),
`ifdef ONCHIP_RAM_DP_PARITY_EN
    .s1_parity_err(l2_s1_parity_err), .s2_parity_err(l2_s2_parity_err),
`endif
    .init_done(l2_init_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          wr;
    bit [1:0]    port;
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;  // write data, or expected read data
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0;
  endtask

  task automatic set_port(input int p, input bit rd, input bit wr, input logic [AW-1:0] a,
                          input logic [3:0] be, input logic [31:0] d);
    if (p == 1) begin
      s1_chipselect = 1; s1_read = rd; s1_write = wr; s1_address = a; s1_byteenable = be; s1_writedata = d;
    end else begin
      s2_chipselect = 1; s2_read = rd; s2_write = wr; s2_address = a; s2_byteenable = be; s2_writedata = d;
    end
  endtask

  task automatic do_write(input int p, input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    set_port(p, 0, 1, a, be, d);
    tick();
    idle();
  endtask

  // Checks latency-1 response right after acceptance, latency-2 response one cycle later.
  task automatic do_read(input int p, input logic [AW-1:0] a, input logic [31:0] exp, input string name);
    set_port(p, 1, 0, a, 4'hF, 32'h0);
    tick();
    idle();
    check1({name, "_l1_vld"}, (p == 1) ? s1_readdatavalid : s2_readdatavalid, 1'b1);
    check({name, "_l1_dat"}, (p == 1) ? s1_readdata : s2_readdata, exp);
    check1({name, "_l2_early"}, (p == 1) ? l2_s1_readdatavalid : l2_s2_readdatavalid, 1'b0);
    tick();
    check1({name, "_l1_pulse"}, (p == 1) ? s1_readdatavalid : s2_readdatavalid, 1'b0);
    check1({name, "_l2_vld"}, (p == 1) ? l2_s1_readdatavalid : l2_s2_readdatavalid, 1'b1);
    check({name, "_l2_dat"}, (p == 1) ? l2_s1_readdata : l2_s2_readdata, exp);
  endtask

  task automatic wait_clear(output int cnt, output bit early);
    cnt = 0;
    early = 0;
    while (s1_waitrequest && cnt < 100) begin
      if (init_done) early = 1;
      cnt++;
      tick();
    end
  endtask

  function automatic logic [31:0] bd(input int i);
    return 32'hA5000000 + 32'(i) * 32'h00010101;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int  cnt;
    bit  early;
    int  idx1, idx2;

    vecs[0] = '{1'b1, 2'd1, 4'd5,  4'hF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 2'd1, 4'd5,  4'h2, 32'h0000AA00};
    vecs[2] = '{1'b0, 2'd2, 4'd5,  4'hF, 32'hDEADAAEF};
    vecs[3] = '{1'b1, 2'd2, 4'd9,  4'hC, 32'h12345678};
    vecs[4] = '{1'b0, 2'd1, 4'd9,  4'hF, 32'h12340000};
    vecs[5] = '{1'b1, 2'd2, 4'd9,  4'h1, 32'h000000FF};
    vecs[6] = '{1'b0, 2'd2, 4'd9,  4'hF, 32'h123400FF};
    vecs[7] = '{1'b1, 2'd1, 4'd15, 4'hF, 32'hCAFEF00D};
    vecs[8] = '{1'b0, 2'd2, 4'd15, 4'hF, 32'hCAFEF00D};
    vecs[9] = '{1'b0, 2'd1, 4'd5,  4'hF, 32'hDEADAAEF};

    reset = 1; reset_req = 0; clken = 1;
    s1_address = '0; s2_address = '0; s1_byteenable = '0; s2_byteenable = '0;
    s1_writedata = '0; s2_writedata = '0;
    idle();
    tick();
    check("rst_rdata", s1_readdata, 32'h0);
    check1("rst_vld", s1_readdatavalid, 1'b0);
    check1("rst_init_done", init_done, 1'b0);
    check1("rst_wait1", s1_waitrequest, 1'b1);
    check1("rst_wait2", s2_waitrequest, 1'b1);
    reset = 0;
    wait_clear(cnt, early);
    check("clear_cycles", 32'(cnt), 32'd16);
    check1("clear_early_done", early, 1'b0);
    check1("clear_init_done", init_done, 1'b1);
    check1("clear_wait2", s2_waitrequest, 1'b0);

    for (int a = 0; a < 16; a++) do_read((a % 2) + 1, AW'(a), 32'h0, "zero");

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) do_write(int'(vecs[i].port), vecs[i].addr, vecs[i].be, vecs[i].data);
      else do_read(int'(vecs[i].port), vecs[i].addr, vecs[i].data, "vec");
    end

    // Same-address collision: s1 wins on shared lanes.
    set_port(1, 0, 1, 4'd3, 4'hF, 32'h11111111);
    set_port(2, 0, 1, 4'd3, 4'hF, 32'h22222222);
    tick(); idle();
    do_read(2, 4'd3, 32'h11111111, "coll_full");
    set_port(1, 0, 1, 4'd3, 4'h3, 32'hAAAAAAAA);
    set_port(2, 0, 1, 4'd3, 4'hE, 32'hBBBBBBBB);
    tick(); idle();
    do_read(1, 4'd3, 32'hBBBBAAAA, "coll_lane");

    // Cross-port read-during-write sees old contents.
    set_port(1, 0, 1, 4'd3, 4'hF, 32'h33333333);
    set_port(2, 1, 0, 4'd3, 4'hF, 32'h0);
    tick(); idle();
    check1("rdw_vld", s2_readdatavalid, 1'b1);
    check("rdw_old", s2_readdata, 32'hBBBBAAAA);
    tick();
    check("rdw_old_l2", l2_s2_readdata, 32'hBBBBAAAA);
    do_read(1, 4'd3, 32'h33333333, "rdw_new");

    // read+write together: write only, no read data.
    set_port(1, 1, 1, 4'd6, 4'hF, 32'h6666AAAA);
    tick(); idle();
    check1("rdwr_novld", s1_readdatavalid, 1'b0);
    tick();
    check1("rdwr_novld_l2", l2_s1_readdatavalid, 1'b0);
    do_read(2, 4'd6, 32'h6666AAAA, "rdwr");

    reset_req = 1; #1;
    check1("rreq_wait1", s1_waitrequest, 1'b1);
    check1("rreq_wait2", s2_waitrequest, 1'b1);
    reset_req = 0;

    // Burst of 8 reads with a 3-cycle clken stall in the middle.
    for (int i = 0; i < 8; i++) do_write(2, AW'(i), 4'hF, bd(i));
    idx1 = 0; idx2 = 0;
    fork
      begin
        int iss = 0;
        for (int c = 0; c < 16; c++) begin
          clken = !(c >= 4 && c <= 6);
          if (clken && iss < 8) begin
            set_port(1, 1, 0, AW'(iss), 4'hF, 32'h0);
            iss++;
          end else idle();
          tick();
        end
        idle();
        clken = 1;
      end
      begin
        for (int c = 0; c < 18; c++) begin
          @(negedge clk);
          if (!clken) begin
            check1("stall_vld_l1", s1_readdatavalid, 1'b0);
            check1("stall_vld_l2", l2_s1_readdatavalid, 1'b0);
          end
          if (s1_readdatavalid) begin
            check("burst_l1", s1_readdata, bd(idx1));
            idx1++;
          end
          if (l2_s1_readdatavalid) begin
            check("burst_l2", l2_s1_readdata, bd(idx2));
            idx2++;
          end
        end
      end
    join
    check("burst_cnt_l1", 32'(idx1), 32'd8);
    check("burst_cnt_l2", 32'(idx2), 32'd8);

    // Reset while clr_addr==7 restarts the full clear.
    reset = 1; tick(); reset = 0;
    repeat (7) tick();
    check1("mid_clear_wait", s1_waitrequest, 1'b1);
    reset = 1; tick(); reset = 0;
    check1("mid_clear_done0", init_done, 1'b0);
    wait_clear(cnt, early);
    check("reclear_cycles", 32'(cnt), 32'd16);
    check1("reclear_early_done", early, 1'b0);
    check1("reclear_init_done", init_done, 1'b1);
    do_read(1, 4'd5, 32'h0, "reclear_zero");
    do_read(2, 4'd15, 32'h0, "reclear_zero15");

`ifdef ONCHIP_RAM_DP_PARITY_EN
    u_dut.r_mem[2][0] = ~u_dut.r_mem[2][0];
    set_port(1, 1, 0, 4'd2, 4'hF, 32'h0);
    tick(); idle();
    check1("par_vld", s1_readdatavalid, 1'b1);
    check1("par_err2", s1_parity_err, 1'b1);
    tick();
    check1("par_err_pulse", s1_parity_err, 1'b0);
    set_port(1, 1, 0, 4'd1, 4'hF, 32'h0);
    tick(); idle();
    check1("par_vld1", s1_readdatavalid, 1'b1);
    check1("par_err1", s1_parity_err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
